// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the memory/writeback back end.
//  - bit positions inside the 8-bit control byte from the ALU stage
//  - memory FSM state encoding
//  - default widths and timeout
package mem_writeback_pkg;

  // Default widths and timeout.
  localparam int unsigned DATA_W_DEF      = 64;
  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned REG_AW_DEF      = 4;
  localparam int unsigned MEM_TIMEOUT_DEF = 15;

  // Control byte bit positions.
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 2;
  localparam int unsigned CBR     = 3;
  localparam int unsigned LD      = 4;
  localparam int unsigned ST      = 5;
  localparam int unsigned RW      = 6;
  localparam int unsigned JMP     = 7;

  // Memory FSM states.
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMemReq  = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  // A result needs the data-memory port if it loads or stores.
  function automatic logic is_mem_op(input logic [7:0] ctrl);
    return ctrl[LD] | ctrl[ST];
  endfunction

endpackage

// File: rtl/mem_writeback_mem_req_fsm.sv
// Data-memory req/ack handshake with timeout.
//  clk, reset          clock, synchronous active-high reset
//  start               accept a load/store (only honoured when idle)
//  start_store         1 = store, 0 = load
//  start_addr/wdata    address and store data to latch
//  mem_ack             one-cycle completion pulse from memory
//  busy                access outstanding (drives upstream stall)
//  mem_req/we/addr/wdata  memory port, stable for the whole access
//  load_done           one-cycle pulse: a load completed this cycle
//  mem_error           sticky timeout flag, cleared only by reset
module mem_req_fsm
  import mem_writeback_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_store,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_done,
  output logic              mem_error
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    load_done = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StMemReq;
      end
      StMemReq: begin
        state_d = StMemWait;
      end
      StMemWait: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_d   = StIdle;
          cnt_d     = '0;
          load_done = ~store_q;
        end else if (cnt_q >= CntW'(MEM_TIMEOUT - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start && state_q == StIdle) begin
      store_q <= start_store;
      addr_q  <= start_addr;
      wdata_q <= start_wdata;
    end
  end

  assign busy      = (state_q != StIdle);
  assign mem_req   = busy;
  assign mem_we    = busy & store_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_error = err_q;

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback back end of the execute interface.
//  Inputs: registered ALU results (in_valid, control byte, value, address, destination
//  register, branch decision/target) and the data-memory response (mem_rdata, mem_ack).
//  Outputs: upstream stall, data-memory request port, register-file write port,
//  one-cycle PC redirect + flush, sticky mem_error.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        control_signals_in,
  input  logic [DATA_W-1:0] value_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [REG_AW-1:0] reg_to_be_written_in,
  input  logic              isBranchTaken,
  input  logic [ADDR_W-1:0] BranchPC,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              mem_error
);

  logic              busy;
  logic              accept;
  logic              mem_op;
  logic              start;
  logic              load_done;
  logic [REG_AW-1:0] reg_q;

  logic              rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              redirect_q;
  logic [ADDR_W-1:0] redirect_pc_q;

  // Opcode, cond-branch and jump bits are resolved upstream.
  logic unused_ctrl;
  assign unused_ctrl = ^{control_signals_in[OPC_MSB:OPC_LSB], control_signals_in[CBR],
                         control_signals_in[JMP]};

  assign accept = in_valid & ~busy;
  assign mem_op = is_mem_op(control_signals_in);
  assign start  = accept & mem_op;

  mem_req_fsm #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_req_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    // Load and store together is a store.
    .start_store (control_signals_in[ST]),
    .start_addr  (address_in),
    .start_wdata (value_in),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .load_done   (load_done),
    .mem_error   (mem_error)
  );

  // Destination register of the outstanding load.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q <= '0;
    end else if (start) begin
      reg_q <= reg_to_be_written_in;
    end
  end

  // load_done and accept are exclusive: a load completes only while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (load_done) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= reg_q;
      rf_wdata_q <= mem_rdata;
    end else if (accept && !mem_op && control_signals_in[RW]) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= reg_to_be_written_in;
      rf_wdata_q <= value_in;
    end else begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q    <= accept & isBranchTaken;
      redirect_pc_q <= (accept && isBranchTaken) ? BranchPC : '0;
    end
  end

  assign stall       = busy;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign pc_redirect = redirect_q;
  assign flush       = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  control_signals_in;
  logic [63:0] value_in;
  logic [7:0]  address_in;
  logic [3:0]  reg_to_be_written_in;
  logic        isBranchTaken;
  logic [7:0]  BranchPC;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        pc_redirect;
  logic [7:0]  redirect_pc;
  logic        flush;
  logic        mem_error;

  mem_writeback dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .control_signals_in   (control_signals_in),
    .value_in             (value_in),
    .address_in           (address_in),
    .reg_to_be_written_in (reg_to_be_written_in),
    .isBranchTaken        (isBranchTaken),
    .BranchPC             (BranchPC),
    .stall                (stall),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack),
    .rf_we                (rf_we),
    .rf_waddr             (rf_waddr),
    .rf_wdata             (rf_wdata),
    .pc_redirect          (pc_redirect),
    .redirect_pc          (redirect_pc),
    .flush                (flush),
    .mem_error            (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: an access is "age" cycles old while mem_req is up
  // (age 1 = request cycle, later ages = wait cycles in which an ack counts).
  logic        model_valid = 1'b0;
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic        m_err = 1'b0;
  logic        m_store = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [3:0]  m_reg = '0;
  logic        e_rf_we = 1'b0;
  logic [3:0]  e_rf_waddr = '0;
  logic [63:0] e_rf_wdata = '0;
  logic        e_redir = 1'b0;
  logic [7:0]  e_rpc = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_age = 0; m_err = 1'b0; m_store = 1'b0;
      m_addr = '0; m_wdata = '0;
      e_rf_we = 1'b0; e_rf_waddr = '0; e_rf_wdata = '0; e_redir = 1'b0; e_rpc = '0;
    end else begin
      e_rf_we = 1'b0; e_rf_waddr = '0; e_rf_wdata = '0; e_redir = 1'b0; e_rpc = '0;
      if (m_busy) begin
        if (m_age >= 2 && mem_ack) begin
          m_busy = 1'b0;
          if (!m_store) begin
            e_rf_we = 1'b1; e_rf_waddr = m_reg; e_rf_wdata = mem_rdata;
          end
        end else if (m_age - 1 == TIMEOUT) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
        end else begin
          m_age++;
        end
      end else if (in_valid) begin
        if (isBranchTaken) begin
          e_redir = 1'b1; e_rpc = BranchPC;
        end
        if (control_signals_in[4] || control_signals_in[5]) begin
          m_busy = 1'b1; m_age = 1; m_store = control_signals_in[5];
          m_addr = address_in; m_wdata = value_in; m_reg = reg_to_be_written_in;
        end else if (control_signals_in[6]) begin
          e_rf_we = 1'b1; e_rf_waddr = reg_to_be_written_in; e_rf_wdata = value_in;
        end
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cmp_stall", stall, m_busy);
      chk("cmp_mem_req", mem_req, m_busy);
      chk("cmp_mem_we", mem_we, m_busy & m_store);
      chk("cmp_mem_addr", mem_addr, m_busy ? m_addr : 8'h0);
      chk("cmp_mem_wdata", mem_wdata, m_busy ? m_wdata : 64'h0);
      chk("cmp_rf_we", rf_we, e_rf_we);
      chk("cmp_rf_waddr", rf_waddr, e_rf_waddr);
      chk("cmp_rf_wdata", rf_wdata, e_rf_wdata);
      chk("cmp_pc_redirect", pc_redirect, e_redir);
      chk("cmp_flush", flush, e_redir);
      chk("cmp_redirect_pc", redirect_pc, e_rpc);
      chk("cmp_mem_error", mem_error, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ctrl, input logic [63:0] val, input logic [7:0] addr,
                       input logic [3:0] rg, input logic taken, input logic [7:0] bpc);
    in_valid = 1'b1; control_signals_in = ctrl; value_in = val; address_in = addr;
    reg_to_be_written_in = rg; isBranchTaken = taken; BranchPC = bpc;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; control_signals_in = '0; value_in = '0; address_in = '0;
    reg_to_be_written_in = '0; isBranchTaken = 1'b0; BranchPC = '0;
  endtask

  int req_cnt;

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    clear_in();
    step(); step();
    chk("reset_stall", stall, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_redirect", pc_redirect, 1'b0);
    chk("reset_mem_error", mem_error, 1'b0);
    reset = 1'b0;

    // ALU add with register write.
    issue(8'h41, 64'h2A, 8'h00, 4'd3, 1'b0, 8'h00);
    step(); clear_in();
    chk("alu_rf_we", rf_we, 1'b1);
    chk("alu_rf_waddr", rf_waddr, 4'd3);
    chk("alu_rf_wdata", rf_wdata, 64'h2A);
    chk("alu_stall", stall, 1'b0);
    step();
    chk("alu_pulse_end", rf_we, 1'b0);

    // ALU op without register write.
    issue(8'h01, 64'h7, 8'h00, 4'd5, 1'b0, 8'h00);
    step(); clear_in();
    chk("alu_norw_rf_we", rf_we, 1'b0);

    // Load, ack in the third wait cycle.
    issue(8'h50, 64'h0, 8'h10, 4'd6, 1'b0, 8'h00);
    step(); clear_in();
    req_cnt = 0;
    chk("ld_req_stall", stall, 1'b1);
    chk("ld_req_addr", mem_addr, 8'h10);
    chk("ld_req_we", mem_we, 1'b0);
    req_cnt += int'(mem_req);
    step(); req_cnt += int'(mem_req);
    step(); req_cnt += int'(mem_req);
    step(); req_cnt += int'(mem_req);
    chk("ld_wait_stall", stall, 1'b1);
    mem_ack = 1'b1; mem_rdata = 64'hDEAD;
    step(); mem_ack = 1'b0; mem_rdata = '0;
    chk("ld_req_cycles", req_cnt, 4);
    chk("ld_req_drop", mem_req, 1'b0);
    chk("ld_rf_we", rf_we, 1'b1);
    chk("ld_rf_wdata", rf_wdata, 64'hDEAD);
    chk("ld_rf_waddr", rf_waddr, 4'd6);
    chk("model_ld_wdata", e_rf_wdata, 64'hDEAD);

    // Store; ack in request cycle is ignored, busy-time input ignored.
    issue(8'h20, 64'h5, 8'h20, 4'd9, 1'b0, 8'h00);
    step(); clear_in();
    chk("st_we", mem_we, 1'b1);
    chk("st_wdata", mem_wdata, 64'h5);
    chk("st_addr", mem_addr, 8'h20);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    chk("st_early_ack_ignored", mem_req, 1'b1);
    issue(8'h41, 64'h99, 8'h00, 4'd2, 1'b0, 8'h00);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0; clear_in();
    chk("st_done", mem_req, 1'b0);
    chk("st_no_rf_we", rf_we, 1'b0);

    // Taken branch.
    issue(8'h08, 64'h0, 8'h00, 4'd0, 1'b1, 8'h44);
    step(); clear_in();
    chk("br_redirect", pc_redirect, 1'b1);
    chk("br_flush", flush, 1'b1);
    chk("br_pc", redirect_pc, 8'h44);
    step();
    chk("br_pulse_end", pc_redirect, 1'b0);
    chk("br_flush_end", flush, 1'b0);

    // Load never acked: timeout.
    issue(8'h50, 64'h0, 8'h30, 4'd7, 1'b0, 8'h00);
    step(); clear_in();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    step();
    chk("to_last_wait_req", mem_req, 1'b1);
    chk("to_last_wait_err", mem_error, 1'b0);
    step();
    chk("to_req_drop", mem_req, 1'b0);
    chk("to_error", mem_error, 1'b1);
    chk("to_no_rf_we", rf_we, 1'b0);
    chk("model_to_error", m_err, 1'b1);

    // mem_error is sticky across later traffic.
    issue(8'h41, 64'h3, 8'h00, 4'd1, 1'b0, 8'h00);
    step(); clear_in();
    chk("sticky_error", mem_error, 1'b1);
    chk("sticky_rf_we", rf_we, 1'b1);

    // Ack in the final wait cycle counts as success.
    issue(8'h10, 64'h0, 8'h40, 4'd8, 1'b0, 8'h00);
    step(); clear_in();
    for (int i = 0; i < TIMEOUT; i++) step();
    mem_ack = 1'b1; mem_rdata = 64'hBEEF;
    step(); mem_ack = 1'b0; mem_rdata = '0;
    chk("limit_ack_rf_we", rf_we, 1'b1);
    chk("limit_ack_wdata", rf_wdata, 64'hBEEF);
    chk("limit_ack_req", mem_req, 1'b0);

    // Load and store together act as a store.
    issue(8'h30, 64'h77, 8'h50, 4'd4, 1'b0, 8'h00);
    step(); clear_in();
    chk("ldst_we", mem_we, 1'b1);
    chk("ldst_wdata", mem_wdata, 64'h77);
    step(); mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    chk("ldst_no_rf_we", rf_we, 1'b0);

    // Branch alongside a load.
    issue(8'h18, 64'h0, 8'h60, 4'd2, 1'b1, 8'h80);
    step(); clear_in();
    chk("brld_redirect", pc_redirect, 1'b1);
    chk("brld_pc", redirect_pc, 8'h80);
    chk("brld_req", mem_req, 1'b1);
    step(); mem_ack = 1'b1; mem_rdata = 64'h1234;
    step(); mem_ack = 1'b0; mem_rdata = '0;
    chk("brld_rf_we", rf_we, 1'b1);
    chk("brld_rf_wdata", rf_wdata, 64'h1234);

    // Stray ack while idle.
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    chk("idle_ack_stall", stall, 1'b0);
    chk("idle_ack_rf_we", rf_we, 1'b0);

    // Reset mid-wait, with an ack arriving on the reset edge.
    issue(8'h50, 64'h0, 8'h70, 4'd3, 1'b0, 8'h00);
    step(); clear_in();
    step(); step();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hF00D;
    step(); mem_ack = 1'b0; mem_rdata = '0;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_error", mem_error, 1'b0);
    chk("rst_mid_rf_we", rf_we, 1'b0);
    reset = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
